// File: rtl/mnist_frame_ctrl_pkg.sv
// Shared types and default geometry for the MNIST frame sequencer
// and the pipeline top that sits behind it.
package mnist_frame_ctrl_pkg;

  localparam int DEF_IMG_SIZE  = 28;
  localparam int DEF_NUM_CLASS = 10;
  localparam int CLASS_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_e;

endpackage

// File: rtl/mnist_frame_ctrl_argmax.sv
// Sequential signed argmax, one element per cycle.
// Ties keep the lowest index; result is valid alongside done_o.
module seq_argmax
  import mnist_frame_ctrl_pkg::*;
#(
  parameter int N   = 8,
  parameter int NUM = DEF_NUM_CLASS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [NUM*N-1:0]          vec_i,
  output logic                      done_o,
  output logic [CLASS_W-1:0]        idx_o,
  output logic signed [N-1:0]       val_o
);

  localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM - 1);

  logic                      run_q, run_d;
  logic [CLASS_W-1:0]        i_q, i_d;
  logic [CLASS_W-1:0]        bi_q, bi_d;
  logic signed [N-1:0]       bv_q, bv_d;
  logic signed [N-1:0]       cand;
  logic                      take;

  assign cand = vec_i[int'(i_q)*N +: N];

  // Element 0 seeds the best; later ones win only when strictly greater.
  assign take   = (i_q == '0) || (cand > bv_q);
  assign done_o = run_q && (i_q == LAST);
  assign idx_o  = take ? i_q  : bi_q;
  assign val_o  = take ? cand : bv_q;

  always_comb begin
    run_d = run_q;
    i_d   = i_q;
    bi_d  = bi_q;
    bv_d  = bv_q;
    if (start_i) begin
      run_d = 1'b1;
      i_d   = '0;
    end else if (run_q) begin
      bi_d = idx_o;
      bv_d = val_o;
      if (i_q == LAST) begin
        run_d = 1'b0;
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      i_q   <= '0;
      bi_q  <= '0;
      bv_q  <= '0;
    end else begin
      run_q <= run_d;
      i_q   <= i_d;
      bi_q  <= bi_d;
      bv_q  <= bv_d;
    end
  end

endmodule

// File: rtl/mnist_frame_ctrl.sv
// Frame sequencer: streams one image into the pipeline, waits for
// end-of-frame, captures the scores and reports their argmax.
module mnist_frame_ctrl
  import mnist_frame_ctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter int IMG_SIZE  = DEF_IMG_SIZE,
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int PIX_GAP   = 0,
  parameter int TIMEOUT   = 4096,
  parameter int AW        = $clog2(IMG_SIZE*IMG_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   img_rd,
  output logic [AW-1:0]          img_addr,
  input  logic [N-1:0]           img_rdata,
  output logic                   input_vld,
  output logic [N-1:0]           input_din,
  input  logic [NUM_CLASS*N-1:0] conv_dout,
  input  logic                   conv_dout_vld,
  input  logic                   conv_dout_end,
  output logic [CLASS_W-1:0]     class_id,
  output logic [N-1:0]           class_score,
  output logic                   done,
  output logic                   err
);

  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int GW   = (PIX_GAP > 0) ? $clog2(PIX_GAP + 1) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [GW-1:0] GAP_RLD  = GW'(PIX_GAP);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [AW-1:0]            pix_q, pix_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [NUM_CLASS*N-1:0]   cap_q, cap_d;
  logic [CLASS_W-1:0]       cid_q, cid_d;
  logic [N-1:0]             csc_q, csc_d;
  logic                     err_q, err_d;
  logic                     vld_q;

  logic                     am_start;
  logic                     am_done;
  logic [CLASS_W-1:0]       am_idx;
  logic signed [N-1:0]      am_val;

  assign busy        = (state_q != S_IDLE);
  assign img_rd      = (state_q == S_FEED) && (gap_q == '0);
  assign img_addr    = img_rd ? pix_q : '0;
  assign input_vld   = vld_q;
  assign input_din   = vld_q ? img_rdata : '0;
  assign done        = (state_q == S_DONE);
  assign class_id    = cid_q;
  assign class_score = csc_q;
  assign err         = err_q;

  // Capture register is stable through ARGMAX, so the walk reads it directly.
  assign am_start = (state_q == S_DRAIN) && conv_dout_end;

  seq_argmax #(
    .N   (N),
    .NUM (NUM_CLASS)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (am_start),
    .vec_i   (cap_q),
    .done_o  (am_done),
    .idx_o   (am_idx),
    .val_o   (am_val)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    cap_d   = cap_q;
    cid_d   = cid_q;
    csc_d   = csc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          pix_d   = '0;
          gap_d   = '0;
          err_d   = 1'b0;
          cap_d   = '0;
        end
      end
      S_FEED: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          gap_d = GAP_RLD;
          if (pix_q == PIX_LAST) begin
            state_d = S_DRAIN;
            tmo_d   = '0;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (conv_dout_vld) begin
          cap_d = conv_dout;
        end
        if (conv_dout_end) begin
          state_d = S_ARGMAX;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        if (am_done) begin
          state_d = S_DONE;
          cid_d   = am_idx;
          csc_d   = am_val;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      cap_q   <= '0;
      cid_q   <= '0;
      csc_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      cap_q   <= cap_d;
      cid_q   <= cid_d;
      csc_q   <= csc_d;
      err_q   <= err_d;
      vld_q   <= img_rd;
    end
  end

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// Directed bench for mnist_frame_ctrl: ramp image, argmax, timeout,
// back-to-back frames, async abort and a PIX_GAP=2 instance.
module tb_mnist_frame_ctrl;
  import mnist_frame_ctrl_pkg::*;

  localparam int N  = 8;
  localparam int NC = 10;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start, busy, img_rd, input_vld;
  logic [AW-1:0]    img_addr;
  logic [N-1:0]     img_rdata, input_din, class_score;
  logic [NC*N-1:0]  conv_dout;
  logic             conv_vld, conv_end, done, err;
  logic [3:0]       class_id;

  logic             start_g, busy_g, img_rd_g, input_vld_g;
  logic [AW-1:0]    img_addr_g;
  logic [N-1:0]     img_rdata_g, input_din_g, class_score_g;
  logic             done_g, err_g;
  logic [3:0]       class_id_g;

  mnist_frame_ctrl #(.PIX_GAP(0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .img_rd(img_rd), .img_addr(img_addr), .img_rdata(img_rdata),
    .input_vld(input_vld), .input_din(input_din),
    .conv_dout(conv_dout), .conv_dout_vld(conv_vld),
    .conv_dout_end(conv_end), .class_id(class_id),
    .class_score(class_score), .done(done), .err(err)
  );

  mnist_frame_ctrl #(.PIX_GAP(2), .TIMEOUT(16)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start_g), .busy(busy_g),
    .img_rd(img_rd_g), .img_addr(img_addr_g),
    .img_rdata(img_rdata_g), .input_vld(input_vld_g),
    .input_din(input_din_g), .conv_dout('0), .conv_dout_vld(1'b0),
    .conv_dout_end(1'b0), .class_id(class_id_g),
    .class_score(class_score_g), .done(done_g), .err(err_g)
  );

  // Ramp image RAM: pixel k = k mod 256, one-cycle read latency.
  always_ff @(posedge clk) begin
    img_rdata   <= 8'(img_addr);
    img_rdata_g <= 8'(img_addr_g);
  end

  int passed = 0;
  int total  = 0;
  int sc [NC];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*N-1:0] packsc();
    logic [NC*N-1:0] v;
    for (int k = 0; k < NC; k++) v[k*N +: N] = N'(sc[k]);
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({busy, img_rd, img_addr, input_vld, input_din,
                done, err, class_id, class_score});
  endfunction

  // Entered in start cycle T; returns in cycle T+786 (second DRAIN cycle).
  task automatic feed_frame(input int pulse_at, output int errs,
                            output int beats);
    logic rd_exp, vld_exp;
    errs  = 0;
    beats = 0;
    for (int c = 1; c <= 786; c++) begin
      tick();
      start     = (c == pulse_at);
      conv_vld  = (c == 100);
      conv_end  = (c == 100);
      conv_dout = (c == 100) ? {8'h7f, 72'h0} : '0;
      rd_exp  = (c <= 784);
      vld_exp = (c >= 2) && (c <= 785);
      if (img_rd !== rd_exp) errs++;
      if (rd_exp && img_addr !== AW'(c - 1)) errs++;
      if (input_vld !== vld_exp) errs++;
      if (input_vld) begin
        if (input_din !== 8'(beats)) errs++;
        beats++;
      end
      if (busy !== 1'b1) errs++;
    end
  endtask

  int e, b, rd, last;
  logic prev_rd, rd_exp;

  initial begin
    start = 0; start_g = 0;
    conv_vld = 0; conv_end = 0; conv_dout = '0;
    rst_n = 0;
    #12;
    chk("reset_outputs", outs(), 64'(0));
    rst_n = 1;
    tick();

    // Frame 1: ramp, mid-FEED start ignored, vld+end together
    start = 1;
    feed_frame(300, e, b);
    chk("f1_feed_errs", 64'(e), 64'(0));
    chk("f1_beats", 64'(b), 64'(784));
    sc = '{-5, 3, 7, 7, -128, 0, 1, 2, 6, -1};
    conv_dout = packsc(); conv_vld = 1; conv_end = 1;
    tick();
    conv_dout = '0; conv_vld = 0; conv_end = 0;
    e = int'(done);
    repeat (9) begin tick(); e += int'(done); end
    chk("f1_early_done", 64'(e), 64'(0));
    tick();
    chk("f1_done", 64'(done), 64'(1));
    chk("f1_class_id", 64'(class_id), 64'(2));
    chk("f1_class_score", 64'(class_score), 64'(7));
    chk("f1_err", 64'(err), 64'(0));
    tick();
    chk("f1_busy_fall", 64'({busy, done}), 64'(0));

    // Frame 2: back-to-back start, capture overwrite, end without vld
    start = 1;
    feed_frame(0, e, b);
    chk("f2_feed_errs", 64'(e), 64'(0));
    chk("f2_beats", 64'(b), 64'(784));
    sc = '{0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
    conv_dout = packsc(); conv_vld = 1;
    tick();
    sc = '{-3, -3, -3, -3, -3, -3, -3, -3, 50, -3};
    conv_dout = packsc();
    tick();
    conv_dout = {NC{8'h7f}}; conv_vld = 0; conv_end = 1;
    tick();
    conv_dout = '0; conv_end = 0;
    repeat (10) tick();
    chk("f2_done", 64'(done), 64'(1));
    chk("f2_class_id", 64'(class_id), 64'(8));
    chk("f2_class_score", 64'(class_score), 64'(50));
    tick();

    // Frame 3: no end -> timeout, done 17 cycles after last read
    start = 1;
    feed_frame(0, e, b);
    chk("f3_feed_errs", 64'(e), 64'(0));
    e = int'(done);
    repeat (14) begin tick(); e += int'(done); end
    chk("f3_early_done", 64'(e), 64'(0));
    tick();
    chk("f3_done", 64'(done), 64'(1));
    chk("f3_err", 64'(err), 64'(1));
    chk("f3_class_kept", 64'({class_id, class_score}), 64'({4'd8, 8'd50}));
    tick();
    chk("f3_err_sticky", 64'({busy, err}), 64'({1'b0, 1'b1}));

    // Frame 4: start clears err, then async reset at pixel 400
    start = 1;
    tick();
    start = 0;
    chk("f4_err_clear", 64'({busy, err, img_addr}), 64'({1'b1, 1'b0, 10'd0}));
    repeat (400) tick();
    chk("f4_addr400", 64'(img_addr), 64'(400));
    #2 rst_n = 0;
    #1;
    chk("async_reset", outs(), 64'(0));
    tick(); tick();
    rst_n = 1;
    tick();
    chk("post_reset_idle", outs(), 64'(0));

    // Frame 5: fresh full frame after reset, signed tie -> lowest index
    start = 1;
    feed_frame(0, e, b);
    chk("f5_feed_errs", 64'(e), 64'(0));
    chk("f5_beats", 64'(b), 64'(784));
    sc = '{-9, -2, -2, -7, -2, -100, -50, -2, -3, -8};
    conv_dout = packsc(); conv_vld = 1; conv_end = 1;
    tick();
    conv_dout = '0; conv_vld = 0; conv_end = 0;
    repeat (10) tick();
    chk("f5_done", 64'(done), 64'(1));
    chk("f5_class", 64'({class_id, class_score}), 64'({4'd1, 8'hfe}));
    chk("f5_err", 64'(err), 64'(0));

    // PIX_GAP=2 instance: one read every 3 cycles, last at T+1+783*3
    tick();
    start_g = 1;
    e = 0; rd = 0; last = 0; prev_rd = 0;
    for (int c = 1; c <= 2352; c++) begin
      tick();
      start_g = 0;
      rd_exp = (c <= 2350) && ((c - 1) % 3 == 0);
      if (img_rd_g !== rd_exp) e++;
      if (rd_exp && img_addr_g !== AW'((c - 1) / 3)) e++;
      if (input_vld_g !== prev_rd) e++;
      if (input_vld_g && input_din_g !== 8'((rd - 1))) e++;
      if (img_rd_g) begin rd++; last = c; end
      prev_rd = rd_exp;
    end
    chk("gap_errs", 64'(e), 64'(0));
    chk("gap_reads", 64'(rd), 64'(784));
    chk("gap_last_read", 64'(last), 64'(2350));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
